mult_fu_pipe: RTL and testbench

//  Pipelined 64-bit integer multiply functional unit sitting directly downstream of the RS.

---
 rtl/mult_fu_pipe_pkg.sv | 29 ++
 rtl/mult_stage.sv | 40 ++++
 rtl/mult_fu_pipe.sv | 90 +++++++++
 tb/tb_mult_fu_pipe.sv | 348 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mult_fu_pipe_pkg.sv
// Shared types for the pipelined multiply functional unit: tag width, stage record and
// the per-stage partial-product helper.
package mult_fu_pipe_pkg;

  localparam int unsigned Xlen          = 64;
  localparam int unsigned PhysRegW      = 7;
  localparam int unsigned NumMultStages = 4;

  typedef logic [PhysRegW-1:0] phys_reg_t;

  // One pipeline register: a is pre-shifted and b pre-consumed so every stage sees its chunk
  // in the low bits.
  typedef struct packed {
    logic            valid;
    phys_reg_t       tag;
    logic [Xlen-1:0] a;
    logic [Xlen-1:0] b;
    logic [Xlen-1:0] partial;
  } mult_stage_t;

  // a times the low chunk_w bits of b, modulo 2^Xlen.
  function automatic logic [Xlen-1:0] chunk_product(logic [Xlen-1:0] a, logic [Xlen-1:0] b,
                                                    int unsigned chunk_w);
    logic [Xlen-1:0] mask;
    mask = ~({Xlen{1'b1}} << chunk_w);
    return a * (b & mask);
  endfunction

endpackage

// File: rtl/mult_stage.sv
// One multiply pipeline step: adds a * b[chunk] to the running partial product and registers
// the result, with a hold (stall) and a synchronous clear (reset / flush).
module mult_stage
  import mult_fu_pipe_pkg::*;
#(
  parameter int unsigned ChunkW = 16
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        flush_i,
  input  logic        hold_i,
  input  mult_stage_t stage_i,
  output mult_stage_t stage_o
);

  mult_stage_t stage_d, stage_q;

  // An empty slot loads all-zero so its tag reads 0 once invalidated.
  always_comb begin
    stage_d = '0;
    if (stage_i.valid) begin
      stage_d.valid   = 1'b1;
      stage_d.tag     = stage_i.tag;
      stage_d.a       = stage_i.a << ChunkW;
      stage_d.b       = stage_i.b >> ChunkW;
      stage_d.partial = stage_i.partial + chunk_product(stage_i.a, stage_i.b, ChunkW);
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni || flush_i) begin
      stage_q <= '0;
    end else if (!hold_i) begin
      stage_q <= stage_d;
    end
  end

  assign stage_o = stage_q;

endmodule

// File: rtl/mult_fu_pipe.sv
// Pipelined 64-bit integer multiply FU between the RS issue slot and the CDB arbiter.
// Define MULT_FU_SQUASH_EN to let squash flush in-flight work; otherwise squash is ignored.
module mult_fu_pipe
  import mult_fu_pipe_pkg::*;
#(
  parameter int unsigned NUM_STAGES = NumMultStages,
  parameter int unsigned XLEN       = Xlen
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                issue_valid,
  input  logic [PhysRegW-1:0] issue_T,
  input  logic [XLEN-1:0]     issue_opa,
  input  logic [XLEN-1:0]     issue_opb,
  output logic                issue_ready,
  input  logic                squash,
  input  logic                cdb_grant,
  output logic                out_valid,
  output logic [PhysRegW-1:0] out_T,
  output logic [XLEN-1:0]     out_result,
  output logic                busy
);

  localparam int unsigned ChunkW = XLEN / NUM_STAGES;

  mult_stage_t issue_stage;
  mult_stage_t stage_out [NUM_STAGES];
  logic        stall;
  logic        accept;
  logic        flush;

  // Whole pipe freezes while the finished result waits for the CDB; no bubble collapse.
  assign stall       = stage_out[NUM_STAGES-1].valid & ~cdb_grant;
  assign issue_ready = ~stall;
  assign accept      = issue_valid & issue_ready;

`ifdef MULT_FU_SQUASH_EN
  assign flush = squash;
`else
  logic unused_squash;
  assign flush         = 1'b0;
  assign unused_squash = squash;
`endif

  always_comb begin
    issue_stage = '0;
    if (accept) begin
      issue_stage.valid = 1'b1;
      issue_stage.tag   = issue_T;
      issue_stage.a     = issue_opa;
      issue_stage.b     = issue_opb;
    end
  end

  for (genvar k = 0; k < NUM_STAGES; k++) begin : g_stage
    mult_stage_t stage_in;
    if (k == 0) begin : g_first
      assign stage_in = issue_stage;
    end else begin : g_rest
      assign stage_in = stage_out[k-1];
    end

    mult_stage #(
      .ChunkW(ChunkW)
    ) u_stage (
      .clk_i  (clock),
      .rst_ni (reset),
      .flush_i(flush),
      .hold_i (stall),
      .stage_i(stage_in),
      .stage_o(stage_out[k])
    );
  end

  always_comb begin
    busy = 1'b0;
    for (int i = 0; i < NUM_STAGES; i++) begin
      busy = busy | stage_out[i].valid;
    end
  end

  assign out_valid  = stage_out[NUM_STAGES-1].valid;
  assign out_T      = stage_out[NUM_STAGES-1].tag;
  assign out_result = stage_out[NUM_STAGES-1].partial;

  // The last stage's shifted operands have no consumer.
  logic unused_tail;
  assign unused_tail = ^{stage_out[NUM_STAGES-1].a, stage_out[NUM_STAGES-1].b};

endmodule

// File: tb/tb_mult_fu_pipe.sv
// Self-checking bench for mult_fu_pipe: scoreboard of expected {tag, product} popped on grant.
module tb_mult_fu_pipe;

  logic        clock;
  logic        reset;
  logic        issue_valid;
  logic [6:0]  issue_T;
  logic [63:0] issue_opa;
  logic [63:0] issue_opb;
  logic        issue_ready;
  logic        squash;
  logic        cdb_grant;
  logic        out_valid;
  logic [6:0]  out_T;
  logic [63:0] out_result;
  logic        busy;

  int          n_cmp = 0;
  int          n_err = 0;
  logic [70:0] exp_q[$];
  logic [70:0] exp_e;
  bit          squash_en;

  initial clock = 1'b0;
  always #5 clock = ~clock;

  mult_fu_pipe dut (
    .clock      (clock),
    .reset      (reset),
    .issue_valid(issue_valid),
    .issue_T    (issue_T),
    .issue_opa  (issue_opa),
    .issue_opb  (issue_opb),
    .issue_ready(issue_ready),
    .squash     (squash),
    .cdb_grant  (cdb_grant),
    .out_valid  (out_valid),
    .out_T      (out_T),
    .out_result (out_result),
    .busy       (busy)
  );

  // Inputs change only at posedge+1, so the negedge view is what the next edge will see.
  always @(negedge clock) begin
    if (!reset) exp_q.delete();
    else if (squash_en && squash) exp_q.delete();
    else if (issue_valid && issue_ready) exp_q.push_back({issue_T, issue_opa * issue_opb});
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic drive(input logic v, input logic [6:0] t, input logic [63:0] a,
                       input logic [63:0] b);
    issue_valid = v;
    issue_T     = t;
    issue_opa   = a;
    issue_opb   = b;
  endtask

  task automatic test_reset();
    reset = 1'b0; squash = 1'b0; cdb_grant = 1'b0;
    drive(1'b1, 7'd1, 64'd5, 64'd5);
    repeat (2) @(posedge clock);
    @(negedge clock);
    n_cmp++;
    if ({out_valid, busy} !== 2'b00) begin
      n_err++; $display("FAIL reset_outputs: out_valid,busy=%b required 00", {out_valid, busy});
    end
    tick();
    reset = 1'b1;
    drive(1'b0, 7'd0, 64'd0, 64'd0);
    tick();
    @(negedge clock);
    n_cmp++;
    if ({issue_ready, out_valid, busy} !== 3'b100) begin
      n_err++;
      $display("FAIL reset_release: ready,out_valid,busy=%b required 100",
               {issue_ready, out_valid, busy});
    end
    tick();
  endtask

  task automatic test_single();
    cdb_grant = 1'b1;
    drive(1'b1, 7'd3, 64'd6, 64'd7);
    tick();
    drive(1'b0, 7'd0, 64'd0, 64'd0);
    for (int i = 1; i <= 4; i++) begin
      if (i > 1) tick();
      @(negedge clock);
      n_cmp++;
      if (out_valid !== (i == 4)) begin
        n_err++; $display("FAIL single_latency edge %0d: out_valid=%b required %b", i,
                          out_valid, (i == 4));
      end
    end
    n_cmp++;
    if ({out_T, out_result} !== {7'd3, 64'd42}) begin
      n_err++; $display("FAIL single_result: T=%0d r=%0d required T=3 r=42", out_T, out_result);
    end
    if (exp_q.size() != 0) void'(exp_q.pop_front());
    tick();
    @(negedge clock);
    n_cmp++;
    if ({out_valid, busy} !== 2'b00) begin
      n_err++; $display("FAIL single_after: out_valid,busy=%b required 00", {out_valid, busy});
    end
    tick();
  endtask

  task automatic test_back_to_back();
    int got = 0;
    int first = -1;
    int last = -1;
    cdb_grant = 1'b1;
    drive(1'b1, 7'd3, 64'd2, 64'd3);
    tick();
    drive(1'b1, 7'd4, 64'hFFFF_FFFF_FFFF_FFFF, 64'd2);
    tick();
    drive(1'b1, 7'd5, 64'h1_0000_0000, 64'h1_0000_0000);
    tick();
    drive(1'b0, 7'd0, 64'd0, 64'd0);
    for (int c = 0; c < 10; c++) begin
      @(negedge clock);
      if (out_valid && cdb_grant) begin
        got++;
        if (first < 0) first = c;
        last = c;
        n_cmp++;
        if (exp_q.size() == 0) begin
          n_err++; $display("FAIL b2b_extra: T=%0d r=%h required none", out_T, out_result);
        end else begin
          exp_e = exp_q.pop_front();
          if ({out_T, out_result} !== exp_e) begin
            n_err++; $display("FAIL b2b_result: T=%0d r=%h required T=%0d r=%h", out_T,
                              out_result, exp_e[70:64], exp_e[63:0]);
          end
        end
      end
    end
    n_cmp++;
    if (got != 3 || last - first != 2) begin
      n_err++; $display("FAIL b2b_count: got %0d over %0d cycles required 3 over 3", got,
                        last - first + 1);
    end
    tick();
  endtask

  task automatic test_stall();
    int got = 0;
    logic [70:0] held;
    bit seen = 1'b0;
    cdb_grant = 1'b0;
    drive(1'b1, 7'd10, 64'd11, 64'd13);
    tick();
    drive(1'b1, 7'd11, 64'h1234_5678_9ABC_DEF0, 64'h0FED_CBA9_8765_4321);
    tick();
    drive(1'b1, 7'd12, 64'hFFFF_FFFF_FFFF_FFFD, 64'hFFFF_FFFF_FFFF_FFFB);
    tick();
    drive(1'b0, 7'd0, 64'd0, 64'd0);
    for (int c = 0; c < 10 && !seen; c++) begin
      @(negedge clock);
      seen = out_valid;
    end
    n_cmp++;
    if (!seen || issue_ready !== 1'b0) begin
      n_err++; $display("FAIL stall_enter: out_valid=%b ready=%b required 1 0", out_valid,
                        issue_ready);
    end
    held = {out_T, out_result};
    tick();
    drive(1'b1, 7'd20, 64'd3, 64'd3);
    for (int c = 0; c < 3; c++) begin
      @(negedge clock);
      n_cmp++;
      if ({out_valid, issue_ready, busy, out_T, out_result} !== {3'b101, held}) begin
        n_err++; $display("FAIL stall_hold: v=%b rdy=%b T=%0d r=%h required 1 0 T=%0d r=%h",
                          out_valid, issue_ready, out_T, out_result, held[70:64], held[63:0]);
      end
      tick();
    end
    drive(1'b0, 7'd0, 64'd0, 64'd0);
    cdb_grant = 1'b1;
    for (int c = 0; c < 8; c++) begin
      @(negedge clock);
      if (out_valid && cdb_grant) begin
        got++;
        n_cmp++;
        if (exp_q.size() == 0) begin
          n_err++; $display("FAIL stall_extra: T=%0d r=%h required none", out_T, out_result);
        end else begin
          exp_e = exp_q.pop_front();
          if ({out_T, out_result} !== exp_e) begin
            n_err++; $display("FAIL stall_drain: T=%0d r=%h required T=%0d r=%h", out_T,
                              out_result, exp_e[70:64], exp_e[63:0]);
          end
        end
      end
    end
    n_cmp++;
    if (got != 3 || busy !== 1'b0) begin
      n_err++; $display("FAIL stall_count: got %0d busy=%b required 3 0", got, busy);
    end
    tick();
  endtask

  task automatic test_squash();
    int got = 0;
    int want;
    want = squash_en ? 0 : 4;
    cdb_grant = 1'b1;
    drive(1'b1, 7'd13, 64'd100, 64'd200);
    tick();
    drive(1'b1, 7'd14, 64'd7, 64'd9);
    tick();
    drive(1'b1, 7'd15, 64'hDEAD_BEEF, 64'hCAFE);
    tick();
    drive(1'b1, 7'd9, 64'd1, 64'd1);
    squash = 1'b1;
    tick();
    squash = 1'b0;
    drive(1'b0, 7'd0, 64'd0, 64'd0);
    for (int c = 0; c < 10; c++) begin
      @(negedge clock);
      if (c == 0) begin
        n_cmp++;
        if ({busy, out_valid} !== {2{!squash_en}}) begin
          n_err++; $display("FAIL squash_flush: busy,out_valid=%b required %b",
                            {busy, out_valid}, {2{!squash_en}});
        end
      end
      if (out_valid && cdb_grant) begin
        got++;
        n_cmp++;
        if (exp_q.size() == 0) begin
          n_err++; $display("FAIL squash_extra: T=%0d r=%h required none", out_T, out_result);
        end else begin
          exp_e = exp_q.pop_front();
          if ({out_T, out_result} !== exp_e) begin
            n_err++; $display("FAIL squash_result: T=%0d r=%h required T=%0d r=%h", out_T,
                              out_result, exp_e[70:64], exp_e[63:0]);
          end
        end
      end
    end
    n_cmp++;
    if (got != want) begin
      n_err++; $display("FAIL squash_count: got %0d required %0d", got, want);
    end
    tick();
  endtask

  task automatic test_reset_mid_stall();
    bit seen = 1'b0;
    cdb_grant = 1'b0;
    drive(1'b1, 7'd21, 64'd5, 64'd5);
    tick();
    drive(1'b0, 7'd0, 64'd0, 64'd0);
    for (int c = 0; c < 10 && !seen; c++) begin
      @(negedge clock);
      seen = out_valid;
    end
    n_cmp++;
    if (!seen || out_result !== 64'd25) begin
      n_err++; $display("FAIL rst_stall_setup: out_valid=%b r=%0d required 1 25", out_valid,
                        out_result);
    end
    tick();
    reset = 1'b0;
    drive(1'b1, 7'd22, 64'd2, 64'd2);
    tick();
    @(negedge clock);
    n_cmp++;
    if ({out_valid, busy, out_T, out_result} !== 73'd0) begin
      n_err++; $display("FAIL rst_stall_clear: v=%b busy=%b T=%0d r=%h required all 0",
                        out_valid, busy, out_T, out_result);
    end
    tick();
    reset = 1'b1;
    drive(1'b0, 7'd0, 64'd0, 64'd0);
    tick();
    @(negedge clock);
    n_cmp++;
    if ({issue_ready, busy} !== 2'b10) begin
      n_err++; $display("FAIL rst_stall_release: ready,busy=%b required 10", {issue_ready, busy});
    end
    tick();
  endtask

  task automatic test_random();
    for (int c = 0; c < 80; c++) begin
      if (c < 60) begin
        drive(1'($urandom_range(0, 1)), 7'($urandom_range(0, 127)), {$urandom, $urandom},
              {$urandom, $urandom});
        cdb_grant = ($urandom_range(0, 3) != 0);
      end else begin
        drive(1'b0, 7'd0, 64'd0, 64'd0);
        cdb_grant = 1'b1;
      end
      @(negedge clock);
      if (out_valid && cdb_grant) begin
        n_cmp++;
        if (exp_q.size() == 0) begin
          n_err++; $display("FAIL rand_extra: T=%0d r=%h required none", out_T, out_result);
        end else begin
          exp_e = exp_q.pop_front();
          if ({out_T, out_result} !== exp_e) begin
            n_err++; $display("FAIL rand_result: T=%0d r=%h required T=%0d r=%h", out_T,
                              out_result, exp_e[70:64], exp_e[63:0]);
          end
        end
      end
      tick();
    end
    n_cmp++;
    if (exp_q.size() != 0 || busy !== 1'b0) begin
      n_err++; $display("FAIL rand_leftover: %0d pending busy=%b required 0 0", exp_q.size(),
                        busy);
    end
  endtask

  initial begin
`ifdef MULT_FU_SQUASH_EN
    squash_en = 1'b1;
`else
    squash_en = 1'b0;
`endif
    test_reset();
    test_single();
    test_back_to_back();
    test_stall();
    test_squash();
    test_reset_mid_stall();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation still running at 200000, required completion");
    $fatal(1);
  end

endmodule
